seq_frame_tx: RTL
=================

# seq_frame_tx

Serial framed-bit transmitter: on a start handshake it latches a parallel payload and shifts out one bit per clock, as a fixed sync pattern, then the payload MSB-first, then an even-parity bit. It is the sending end of the team's serial sync-detect link, and it drives the single-bit stream that the sequence detectors sample. Outputs are registered (Moore), so the stream is glitch-free and cycle-exact.

## Interface
- SYNC_W, 4, sync pattern width (≥1)
- SYNC_PAT, 4'b1011, sync pattern; sent MSB (bit SYNC_W-1) first
- DATA_W, 8, payload width (≥1)
- GAP, 2, forced idle cycles after each frame (≥0)

- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  request to send; accepted only when ready=1
- data_in  in  DATA_W  payload; sampled on the accepting edge only
- ready  out  1  block idle and able to accept start
- out  out  1  serial bit
- out_valid  out  1  out carries a frame bit this cycle
- frame_done  out  1  one-cycle pulse, coincident with the parity bit

## Operation
- States are IDLE, SYNC, DATA, PARITY and GAP.
- Reset values:
  - State is IDLE.
  - ready=1, out=0, out_valid=0, frame_done=0.
  - Shift register and counters are 0.
- IDLE:
  - ready=1, out=0, out_valid=0.
  - If start=1 on an edge, latch data_in, compute even parity (XOR of all payload bits), clear the bit counter, and go to SYNC.
- SYNC:
  - out = SYNC_PAT[SYNC_W-1-cnt].
  - After SYNC_W bits, go to DATA with the counter cleared.
- DATA:
  - out = payload[DATA_W-1-cnt], MSB first.
  - After DATA_W bits, go to PARITY.
- PARITY:
  - out = parity bit, frame_done=1.
  - Go to GAP if GAP>0, otherwise go to IDLE.
- GAP:
  - out=0, out_valid=0, ready=0.
  - Stay GAP cycles, then go to IDLE.
- out_valid=1 in SYNC, DATA and PARITY only.
- ready=1 in IDLE only.
- A start while ready=0 is ignored, not queued.
- data_in changes after acceptance have no effect on the frame in flight.
- Counter width is clog2(max(SYNC_W, DATA_W, GAP, 2)). Counters never wrap mid-state.

## Timing
- Call the accepting edge E0.
  - First sync bit is valid in the cycle after E0.
  - out_valid stays high for exactly SYNC_W+DATA_W+1 consecutive cycles.
- frame_done is high for exactly 1 cycle, the last valid cycle.
- ready rises GAP+1 cycles after the parity cycle.
  - Minimum start-to-start period is SYNC_W+DATA_W+2+GAP cycles. This is 16 with the defaults.
- Back-to-back: start held high continuously launches a new frame on the first edge where ready=1. There are no extra bubbles beyond GAP and the one IDLE cycle.
- Reset mid-frame:
  - The frame is aborted with no partial completion.
  - All outputs take reset values in the cycle after the reset edge.
  - A start coincident with rst is ignored.
- rst has priority over start on the same edge.

## Test plan
- **Reset:** hold rst 3 cycles with start=1 → ready=1, out=0, out_valid=0, frame_done=0 throughout, and no frame is launched.
- **Single frame, defaults:** data_in=8'hA5 with a 1-cycle start pulse.
  - out over 13 valid cycles: 1,0,1,1, 1,0,1,0,0,1,0,1, 0.
  - frame_done is high only on cycle 13.
  - Then 2 cycles with out_valid=0, and ready=1 on cycle 16.
- **Odd parity payload:** data_in=8'h01 → payload bits 0000_0001, parity bit 1.
  - A 1011 detector sampling out on out_valid flags exactly at the sync's 4th bit.
- **Busy start ignored:** start pulses with data_in=8'hFF during cycles 3 and 9 of an 8'h3C frame.
  - Payload out is 00111100 and parity is 0.
  - No second frame is sent.
- **Back-to-back:** start held high with data_in=8'h00, then 8'hFF.
  - Frames begin exactly 16 cycles apart.
  - Second payload is all ones, parity 0.
- **Reset mid-frame:** assert rst for 1 cycle at the 6th valid bit.
  - Next cycle out_valid=0 and ready=1.
  - A subsequent start with 8'h5A yields a complete, correct 13-bit frame.

Source files
------------

// File: rtl/seq_frame_tx.sv
// Serial framed-bit transmitter: sync pattern, MSB-first payload, even parity.
// Every output is a flop fed from next-state logic, so the stream is glitch-free.
module seq_frame_tx #(
    parameter int unsigned       SYNC_W   = 4,
    parameter logic [SYNC_W-1:0] SYNC_PAT = 4'b1011,
    parameter int unsigned       DATA_W   = 8,
    parameter int unsigned       GAP      = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] data_in,
    output logic              ready,
    output logic              out,
    output logic              out_valid,
    output logic              frame_done
);

    localparam int unsigned MaxSd  = (SYNC_W > DATA_W) ? SYNC_W : DATA_W;
    localparam int unsigned MaxSdg = (MaxSd > GAP) ? MaxSd : GAP;
    localparam int unsigned CntMax = (MaxSdg > 2) ? MaxSdg : 2;
    localparam int unsigned CW     = $clog2(CntMax);
    localparam int unsigned GapM1  = (GAP > 0) ? GAP - 1 : 0;

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StSync   = 3'd1;
    localparam logic [2:0] StData   = 3'd2;
    localparam logic [2:0] StParity = 3'd3;
    localparam logic [2:0] StGap    = 3'd4;

    logic [2:0]        state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0] data_sh_q, data_sh_d;
    logic [SYNC_W-1:0] sync_sh_q, sync_sh_d;
    logic              parity_q, parity_d;
    logic              ready_d, out_d, out_valid_d, frame_done_d;

    // Next state: both shift registers present the bit to send at their MSB.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        data_sh_d = data_sh_q;
        sync_sh_d = sync_sh_q;
        parity_d  = parity_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    data_sh_d = data_in;
                    parity_d  = ^data_in;
                    sync_sh_d = SYNC_PAT;
                    cnt_d     = '0;
                    state_d   = StSync;
                end
            end
            StSync: begin
                if (cnt_q == CW'(SYNC_W - 1)) begin
                    cnt_d   = '0;
                    state_d = StData;
                end else begin
                    cnt_d     = cnt_q + CW'(1);
                    sync_sh_d = sync_sh_q << 1;
                end
            end
            StData: begin
                if (cnt_q == CW'(DATA_W - 1)) begin
                    cnt_d   = '0;
                    state_d = StParity;
                end else begin
                    cnt_d     = cnt_q + CW'(1);
                    data_sh_d = data_sh_q << 1;
                end
            end
            StParity: begin
                cnt_d   = '0;
                state_d = (GAP > 0) ? StGap : StIdle;
            end
            StGap: begin
                if (cnt_q == CW'(GapM1)) begin
                    cnt_d   = '0;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = StIdle;
            end
        endcase
    end

    // Output values for the coming cycle, decoded from the next state.
    always_comb begin
        ready_d      = 1'b0;
        out_d        = 1'b0;
        out_valid_d  = 1'b0;
        frame_done_d = 1'b0;
        case (state_d)
            StIdle: ready_d = 1'b1;
            StSync: begin
                out_d       = sync_sh_d[SYNC_W-1];
                out_valid_d = 1'b1;
            end
            StData: begin
                out_d       = data_sh_d[DATA_W-1];
                out_valid_d = 1'b1;
            end
            StParity: begin
                out_d        = parity_d;
                out_valid_d  = 1'b1;
                frame_done_d = 1'b1;
            end
            default: ;
        endcase
    end

    // State and output registers; reset wins over any start on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            data_sh_q  <= '0;
            sync_sh_q  <= '0;
            parity_q   <= 1'b0;
            ready      <= 1'b1;
            out        <= 1'b0;
            out_valid  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            data_sh_q  <= data_sh_d;
            sync_sh_q  <= sync_sh_d;
            parity_q   <= parity_d;
            ready      <= ready_d;
            out        <= out_d;
            out_valid  <= out_valid_d;
            frame_done <= frame_done_d;
        end
    end

endmodule
